pipelined_mul_unit: RTL and testbench
=====================================

# pipelined_mul_unit

Parametrised, fully pipelined RV32M multiply functional unit for the out-of-order core. It replaces the fixed single-op multiplier with a configurable-depth pipeline that executes MUL, MULH, MULHSU and MULHU. It sits between the issue stage (D side) and the writeback/complete stage (W side). Every instruction carries its sequence number and destination physical register. The unit accepts one operation per cycle under val/rdy backpressure and supports a whole-pipeline flush.

## Interface
- p_seq_num_bits, 5, width of instruction sequence number
- p_num_phys_regs, 36, number of physical registers; preg width PW = $clog2(p_num_phys_regs)
- p_num_stages, 3, pipeline depth in stages; legal range 1..8
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- D_val  in  1  issue request valid
- D_rdy  out  1  unit can accept
- D_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
- D_op1  in  32  rs1 value
- D_op2  in  32  rs2 value
- D_seq_num  in  p_seq_num_bits  instruction tag
- D_preg  in  PW  destination physical register
- W_val  out  1  result valid
- W_rdy  in  1  writeback accepts result
- W_data  out  32  result
- W_seq_num  out  p_seq_num_bits  tag of result
- W_preg  out  PW  destination of result
- flush  in  1  discard all in-flight operations

## Operation
- Transfer occurs on a rising edge where val && rdy. D and W are independent handshakes.
- Stages S0..S(N-1), N = p_num_stages. Each stage holds a valid bit, op, seq_num, preg and partial/full product state.
- S(N-1) drives the W outputs directly. W_val = valid[N-1].
- Stage k advances if valid[k] && (stage k+1 is empty or advancing). The last stage advances on W_rdy. Bubbles collapse: an empty stage never blocks upstream.
- D_rdy = !flush && (!valid[0] || S0 advancing). This signal is combinational and must not depend on D_val.
- Arithmetic: 64-bit product of sign/zero-extended operands.
  - MUL: low 32 bits.
  - MULH: signed×signed, high 32 bits.
  - MULHSU: signed op1 × unsigned op2, high 32 bits.
  - MULHU: unsigned×unsigned, high 32 bits.
- Product computation may be split across stages however the implementation chooses. Only the result leaving S(N-1) is specified.
- Flush: on the edge where flush=1, all valid bits clear. D_rdy=0 during flush, so nothing is accepted that cycle. A W transfer that cycle does not occur: W_val may be 1, but the writeback side must ignore it while flush is high. The bench checks W_val=0 on the cycle after flush.
- When invalid, W_data/W_seq_num/W_preg hold their last values. They are don't-care when W_val=0.
- Ordering: results leave in exactly acceptance order. There is no reordering and no drop except by flush.

## Timing
- Reset: all valid bits 0 immediately (async). W_val=0. D_rdy=1 once rst deasserts. All datapath registers reset to 0.
- Reset mid-operation: all in-flight ops are lost. The first transfer after deassert behaves as from an empty pipe.
- Latency: an op accepted at edge t presents W_val=1 in the cycle after edge t+N-1 (N cycles) when no stall occurs.
- Throughput: 1 op/cycle sustained with W_rdy=1.
- Full: with all N stages valid and W_rdy=0, D_rdy=0.
  - With all stages valid and W_rdy=1, D_rdy=1 in the same cycle; the pipe shifts and the new op enters.
- Simultaneous accept+emit keeps occupancy constant.
- Capacity is exactly N ops.
- p_num_stages=1: S0 is the output stage, with 1-cycle latency and full throughput.

## Test plan
- Basic ops, N=3, W_rdy=1:
  - MUL 3×4 → W_data=0x0000000C, appearing 3 cycles after accept, seq/preg echoed.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
  - MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- Back-to-back: 8 consecutive MULs (op1=i, op2=i+1, seq=i) → 8 results on consecutive cycles, in order, i*(i+1).
- Backpressure: hold W_rdy=0 while issuing → exactly N ops accepted, then D_rdy=0. Release W_rdy → all N emerge in order with no loss or duplication. Random W_rdy pattern against a golden queue of 100 random ops → bit-exact in-order match.
- Flush: issue 3 ops, assert flush for 1 cycle at cycle 2 → W_val=0 next cycle and no flushed seq_num ever appears. An op issued the cycle after flush completes normally.
- Reset mid-op: assert rst asynchronously with 2 ops in flight → W_val drops without waiting for a clock edge. After release, D_rdy=1 and a new MUL 5×7 → 35.
- Parameter sweep: repeat scenarios 1–3 for (N, seq, phys) = (1,5,36), (4,3,33), (8,6,50).

Source files
------------

// File: rtl/pipelined_mul_unit.sv
// Pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU). The 32-bit result is formed as an op
// is accepted and then carried through p_num_stages registered stages with collapsing bubbles.
module pipelined_mul_unit #(
  parameter int p_seq_num_bits  = 5,
  parameter int p_num_phys_regs = 36,
  parameter int p_num_stages    = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               D_val,
  output logic                               D_rdy,
  input  logic [1:0]                         D_op,
  input  logic [31:0]                        D_op1,
  input  logic [31:0]                        D_op2,
  input  logic [p_seq_num_bits-1:0]          D_seq_num,
  input  logic [$clog2(p_num_phys_regs)-1:0] D_preg,
  output logic                               W_val,
  input  logic                               W_rdy,
  output logic [31:0]                        W_data,
  output logic [p_seq_num_bits-1:0]          W_seq_num,
  output logic [$clog2(p_num_phys_regs)-1:0] W_preg,
  input  logic                               flush
);
  localparam int N  = p_num_stages;
  localparam int SW = p_seq_num_bits;
  localparam int PW = $clog2(p_num_phys_regs);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  typedef struct packed {
    logic [31:0]   data;
    logic [SW-1:0] seq_num;
    logic [PW-1:0] preg;
  } stage_t;

  op_e                op;
  logic [N-1:0]       valid;
  logic [N-1:0]       adv;
  logic [N-1:0]       load;
  logic               hole;
  stage_t             stage_q [N];
  stage_t             entry;
  logic signed [32:0] a_ext;
  logic signed [32:0] b_ext;
  logic signed [63:0] prod;

  // One extra sign bit per operand lets a single signed multiply cover all four ops.
  always_comb begin
    op    = op_e'(D_op);
    a_ext = $signed({(op == OP_MULH || op == OP_MULHSU) && D_op1[31], D_op1});
    b_ext = $signed({(op == OP_MULH) && D_op2[31], D_op2});
    prod  = 64'(a_ext) * 64'(b_ext);
    entry = '{data:    (op == OP_MUL) ? prod[31:0] : prod[63:32],
              seq_num: D_seq_num,
              preg:    D_preg};
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    adv  = '0;
    load = '0;
    hole = W_rdy;
    // Walking from the output back, a stage moves if any stage below it is empty or W accepts.
    for (int k = N - 1; k >= 0; k--) begin
      adv[k] = valid[k] && hole;
      hole   = hole || !valid[k];
    end
    D_rdy   = !flush && (!valid[0] || adv[0]);
    load[0] = D_val && D_rdy;
    for (int k = 1; k < N; k++) begin
      load[k] = adv[k-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples the value its
  // upstream neighbour held before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      // NOTE: the stage storage is reset too, so W_data/W_seq_num/W_preg read 0 after reset.
      for (int k = 0; k < N; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (flush)        valid[k] <= 1'b0;
        else if (load[k]) valid[k] <= 1'b1;
        else if (adv[k])  valid[k] <= 1'b0;
      end
      if (load[0]) stage_q[0] <= entry;
      for (int k = 1; k < N; k++) begin
        if (load[k]) stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign W_val     = valid[N-1];
  assign W_data    = stage_q[N-1].data;
  assign W_seq_num = stage_q[N-1].seq_num;
  assign W_preg    = stage_q[N-1].preg;

endmodule

// File: tb/tb_pipelined_mul_unit.sv
// Self-checking bench for pipelined_mul_unit: four parameter sets run side by side, each with
// a vector table, hand-written corner sequences and a queue scoreboard on the W side.
module tb_pipelined_mul_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] data;
    int          seq;
    int          preg;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  // Reference: unsigned 64-bit product, then subtract the signed-operand corrections from the high word.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pu;
    logic [31:0] hi;
    pu = {32'b0, a} * {32'b0, b};
    hi = pu[63:32];
    case (op)
      2'b00:   return pu[31:0];
      2'b01:   return hi - (a[31] ? b : 32'b0) - (b[31] ? a : 32'b0);
      2'b10:   return hi - (a[31] ? b : 32'b0);
      default: return hi;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int N  = (g == 0) ? 3  : (g == 1) ? 1  : (g == 2) ? 4  : 8;
    localparam int SW = (g == 0) ? 5  : (g == 1) ? 5  : (g == 2) ? 3  : 6;
    localparam int NP = (g == 0) ? 36 : (g == 1) ? 36 : (g == 2) ? 33 : 50;
    localparam int PW = $clog2(NP);

    logic          rst = 1'b0;
    logic          d_val = 1'b0;
    logic          d_rdy;
    logic [1:0]    d_op = 2'b00;
    logic [31:0]   d_a = '0;
    logic [31:0]   d_b = '0;
    logic [SW-1:0] d_seq = '0;
    logic [PW-1:0] d_preg = '0;
    logic          w_val;
    logic          w_rdy = 1'b1;
    logic [31:0]   w_data;
    logic [SW-1:0] w_seq;
    logic [PW-1:0] w_preg;
    logic          flush = 1'b0;

    bit   done = 1'b0;
    exp_t q[$];
    int   seen[$];
    int   emit_cyc[$];
    int   cyc = 0;
    int   emitted = 0;

    pipelined_mul_unit #(
      .p_seq_num_bits (SW),
      .p_num_phys_regs(NP),
      .p_num_stages   (N)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .D_val    (d_val),
      .D_rdy    (d_rdy),
      .D_op     (d_op),
      .D_op1    (d_a),
      .D_op2    (d_b),
      .D_seq_num(d_seq),
      .D_preg   (d_preg),
      .W_val    (w_val),
      .W_rdy    (w_rdy),
      .W_data   (w_data),
      .W_seq_num(w_seq),
      .W_preg   (w_preg),
      .flush    (flush)
    );

    function automatic string nm(input string s);
      return $sformatf("N%0d %s", N, s);
    endfunction

    // Scoreboard: handshakes sampled mid-cycle describe the transfers of the next rising edge.
    always @(negedge clk) begin : mon
      exp_t e;
      exp_t want;
      cyc++;
      if (!rst) begin
        if (w_val && w_rdy && !flush) begin
          check(nm("result expected"), q.size() != 0, 1);
          if (q.size() != 0) begin
            want = q.pop_front();
            check(nm("sb data"), w_data, want.data);
            check(nm("sb seq"), w_seq, want.seq);
            check(nm("sb preg"), w_preg, want.preg);
          end
          emitted++;
          seen.push_back(int'(w_seq));
          emit_cyc.push_back(cyc);
        end
        if (flush) q.delete();
        if (d_val && d_rdy) begin
          e.data = ref_mul(d_op, d_a, d_b);
          e.seq  = int'(d_seq);
          e.preg = int'(d_preg);
          q.push_back(e);
        end
      end
    end

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int s, input int p);
      d_op   = op;
      d_a    = a;
      d_b    = b;
      d_seq  = SW'(s);
      d_preg = PW'(p);
    endtask

    // Holds the op until accepted; returns just after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int s, input int p);
      int n;
      n = 0;
      drive(op, a, b, s, p);
      d_val = 1'b1;
      @(negedge clk);
      while (!d_rdy && n < 500) begin
        @(negedge clk);
        n++;
      end
      check(nm("issue accepted"), d_rdy, 1);
      @(posedge clk);
      #1 d_val = 1'b0;
    endtask

    task automatic issue_check(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int s, input int p, input logic [31:0] want, input string name);
      int lat;
      issue(op, a, b, s, p);
      lat = 1;
      @(negedge clk);
      while (!w_val && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      check(nm({name, " latency"}), lat, N);
      check(nm({name, " data"}), w_data, want);
      check(nm({name, " seq"}), w_seq, s & ((1 << SW) - 1));
      check(nm({name, " preg"}), w_preg, p & ((1 << PW) - 1));
      @(posedge clk);
      #1;
    endtask

    task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check(nm("drain"), q.size(), 0);
      @(posedge clk);
      #1;
    endtask

    initial begin : test
      vec_t tab[9];
      int   e0, acc, n, cnt1, cnt2, cnt3;

      tab[0] = '{2'b00, 32'd3,          32'd4,          32'h0000_000C};
      tab[1] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      tab[2] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      tab[3] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      tab[4] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
      tab[5] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
      tab[6] = '{2'b10, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
      tab[7] = '{2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
      tab[8] = '{2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000};

      // Reset state
      #1 rst = 1'b1;
      #2;
      check(nm("reset W_val"), w_val, 0);
      check(nm("reset W_data"), w_data, 0);
      check(nm("reset W_seq"), w_seq, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check(nm("post-reset D_rdy"), d_rdy, 1);
      check(nm("post-reset W_val"), w_val, 0);
      @(posedge clk);
      #1;

      // Vector table, one op at a time
      for (int i = 0; i < 9; i++) begin
        issue_check(tab[i].op, tab[i].a, tab[i].b, i, i + 3, tab[i].res, $sformatf("vec%0d", i));
      end

      // Back-to-back MULs: i*(i+1), consecutive results
      emit_cyc.delete();
      e0 = emitted;
      for (int i = 0; i < 8; i++) issue(2'b00, i, i + 1, i, i);
      drain();
      check(nm("b2b count"), emitted - e0, 8);
      check(nm("b2b consecutive"), emit_cyc[7] - emit_cyc[0], 7);

      // Backpressure: capacity is exactly N
      w_rdy = 1'b0;
      acc = 0;
      e0 = emitted;
      for (int c = 0; c < N + 6; c++) begin
        drive(2'b00, 100 + acc, 3, 16 + acc, acc);
        d_val = 1'b1;
        @(negedge clk);
        if (d_rdy) acc++;
        @(posedge clk);
        #1;
      end
      check(nm("bp accepted"), acc, N);
      @(negedge clk);
      check(nm("bp full D_rdy"), d_rdy, 0);
      @(posedge clk);
      #1 w_rdy = 1'b1;
      @(negedge clk);
      check(nm("full+W_rdy D_rdy"), d_rdy, 1);
      @(posedge clk);
      #1 d_val = 1'b0;
      drain();
      check(nm("bp emitted"), emitted - e0, N + 1);

      // Random ops against random W_rdy
      acc = 0;
      e0 = emitted;
      for (int c = 0; c < 5000 && acc < 100; c++) begin
        w_rdy = ($urandom_range(0, 2) != 0);
        drive(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), $urandom, $urandom);
        d_val = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (d_val && d_rdy) acc++;
        @(posedge clk);
        #1;
      end
      d_val = 1'b0;
      w_rdy = 1'b1;
      drain();
      check(nm("random accepted"), acc, 100);
      check(nm("random emitted"), emitted - e0, 100);

      // Flush with ops in flight; the op offered during flush is taken the cycle after
      seen.delete();
      issue(2'b00, 2, 3, 1, 1);
      issue(2'b00, 4, 5, 2, 2);
      drive(2'b00, 6, 7, 3, 3);
      d_val = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      check(nm("flush D_rdy"), d_rdy, 0);
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check(nm("post-flush W_val"), w_val, 0);
      @(posedge clk);
      #1 d_val = 1'b0;
      drain();
      cnt1 = 0;
      cnt2 = 0;
      cnt3 = 0;
      foreach (seen[i]) begin
        if (seen[i] == 1) cnt1++;
        if (seen[i] == 2) cnt2++;
        if (seen[i] == 3) cnt3++;
      end
      check(nm("flush seq1 seen"), cnt1, (N == 1) ? 1 : 0);
      check(nm("flush seq2 seen"), cnt2, 0);
      check(nm("flush seq3 seen"), cnt3, 1);

      // Asynchronous reset with ops in flight
      w_rdy = 1'b0;
      issue(2'b00, 9, 9, 10, 10);
      if (N >= 2) issue(2'b00, 8, 8, 11, 11);
      n = 0;
      @(negedge clk);
      while (!w_val && n < 100) begin
        @(negedge clk);
        n++;
      end
      check(nm("pre-reset W_val"), w_val, 1);
      #2 rst = 1'b1;
      #1;
      check(nm("async reset W_val"), w_val, 0);
      check(nm("async reset W_data"), w_data, 0);
      q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      w_rdy = 1'b1;
      @(negedge clk);
      check(nm("after reset D_rdy"), d_rdy, 1);
      @(posedge clk);
      #1;
      issue_check(2'b00, 5, 7, 4, 4, 32'd35, "5x7 after reset");
      drain();
      done = 1'b1;
    end
  end

  initial begin : summary
    int t;
    t = 0;
    while (!(cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done) && t < 60000) begin
      @(posedge clk);
      t++;
    end
    check("all configs finished", {cfg[0].done, cfg[1].done, cfg[2].done, cfg[3].done}, 4'hF);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
